// File: rtl/z80_arb_pkg.sv
// Shared types and helpers for the Z80 bus arbiter: FSM state encoding,
// owner identifiers and the one-hot grant helpers.
package z80_arb_pkg;

    localparam int TMR_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_GRANT   = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

    localparam logic       OWNER0   = 1'b0;
    localparam logic       OWNER1   = 1'b1;
    localparam logic [1:0] GNT_NONE = 2'b00;

    // Owner index -> one-hot grant/yield vector
    function automatic logic [1:0] owner_onehot(input logic owner);
        return owner ? 2'b10 : 2'b01;
    endfunction

    // Round-robin pick: on a tie the requester that did not own the bus
    // last time wins; otherwise the single pending requester wins.
    function automatic logic pick_owner(input logic [1:0] req, input logic last_owner);
        return (req == 2'b11) ? ~last_owner : req[1];
    endfunction

endpackage

// File: rtl/z80_arb_timer.sv
// 8-bit loadable, saturating down-counter, advanced only on cen.
// Load wins over decrement; decrement stops at zero.
module z80_arb_timer
    import z80_arb_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cen,
    input  logic             i_load,
    input  logic [TMR_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic [TMR_W-1:0] o_count,
    output logic             o_zero
);

    logic [TMR_W-1:0] r_count;

    // Load or saturating decrement on enabled edges
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (cen) begin
            if (i_load)
                r_count <= i_load_val;
            else if (i_dec && (r_count != '0))
                r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule

// File: rtl/z80_bus_arbiter.sv
// Two-requester bus arbiter in front of a Z80 core. Takes the bus from
// the CPU via busrq_n/busak_n, hands it to one requester round-robin,
// limits hold time (yield) and keeps the CPU on the bus for a minimum
// gap between consecutive external tenures.
module z80_bus_arbiter
    import z80_arb_pkg::*;
#(
    parameter int MAX_HOLD = 64,
    parameter int MIN_CPU  = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cen,
    output logic       busrq_n,
    input  logic       busak_n,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic [1:0] yield,
    output logic       busy
);

    localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(MAX_HOLD);
    localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(MIN_CPU);

    arb_state_t r_state;
    logic       r_owner;
    logic       r_last_owner;
    logic       r_busrq_n;
    logic [1:0] r_gnt;
    logic [1:0] r_yield;
    logic       r_busy;

    arb_state_t       w_next_state;
    logic             w_next_owner;
    logic             w_hold_load;
    logic             w_gap_load;
    logic [TMR_W-1:0] w_hold_cnt;
    logic             w_hold_zero;
    logic [TMR_W-1:0] w_gap_cnt;
    logic             w_gap_zero;
    logic             w_hold_expiring;
    logic [1:0]       w_yield_next;

    // Hold timer: loaded on grant, counts down while granted
    z80_arb_timer u_hold (
        .clk        (clk),
        .reset_n    (reset_n),
        .cen        (cen),
        .i_load     (w_hold_load),
        .i_load_val (HOLD_LOAD),
        .i_dec      (r_state == ST_GRANT),
        .o_count    (w_hold_cnt),
        .o_zero     (w_hold_zero)
    );

    // Gap timer: loaded on return to IDLE, counts down while idle
    z80_arb_timer u_gap (
        .clk        (clk),
        .reset_n    (reset_n),
        .cen        (cen),
        .i_load     (w_gap_load),
        .i_load_val (GAP_LOAD),
        .i_dec      (r_state == ST_IDLE),
        .o_count    (w_gap_cnt),
        .o_zero     (w_gap_zero)
    );

    // Hold counter reaches (or sits at) zero on this edge
    assign w_hold_expiring = w_hold_zero || (w_hold_cnt == TMR_W'(1));

    // Next-state, owner latch and timer load decisions
    always_comb begin
        w_next_state = r_state;
        w_next_owner = r_owner;
        w_hold_load  = 1'b0;
        w_gap_load   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_gap_zero && (req != 2'b00)) begin
                    w_next_state = ST_REQ;
                    w_next_owner = pick_owner(req, r_last_owner);
                end
            end
            ST_REQ: begin
                // A dropped request beats a simultaneous acknowledge
                if (!req[r_owner]) begin
                    w_next_state = ST_RELEASE;
                end else if (!busak_n) begin
                    w_next_state = ST_GRANT;
                    w_hold_load  = 1'b1;
                end
            end
            ST_GRANT: begin
                if (!req[r_owner])
                    w_next_state = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (busak_n) begin
                    w_next_state = ST_IDLE;
                    w_gap_load   = 1'b1;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Yield is registered with lookahead on the hold counter so it is
    // asserted on the same edge the counter reaches zero.
    always_comb begin
        w_yield_next = GNT_NONE;
        if ((r_state == ST_GRANT) && (w_next_state == ST_GRANT) &&
            w_hold_expiring && req[~r_owner])
            w_yield_next = owner_onehot(r_owner);
    end

    // FSM state and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_owner      <= OWNER0;
            r_last_owner <= OWNER1;
            r_busrq_n    <= 1'b1;
            r_gnt        <= GNT_NONE;
            r_yield      <= GNT_NONE;
            r_busy       <= 1'b0;
        end else if (cen) begin
            r_state   <= w_next_state;
            r_owner   <= w_next_owner;
            if (w_gap_load)
                r_last_owner <= r_owner;
            r_busrq_n <= !((w_next_state == ST_REQ) || (w_next_state == ST_GRANT));
            r_gnt     <= (w_next_state == ST_GRANT) ? owner_onehot(w_next_owner) : GNT_NONE;
            r_yield   <= w_yield_next;
            r_busy    <= (w_next_state != ST_IDLE);
        end
    end

    assign busrq_n = r_busrq_n;
    assign gnt     = r_gnt;
    assign yield   = r_yield;
    assign busy    = r_busy;

endmodule

// File: tb/tb_z80_bus_arbiter.sv
// Directed bench for z80_bus_arbiter. Instance A uses MAX_HOLD=4,
// MIN_CPU=4; instance B uses MAX_HOLD=3, MIN_CPU=0. Both share stimulus.
module tb_z80_bus_arbiter;

    logic       clk;
    logic       reset_n;
    logic       cen;
    logic       busak_n;
    logic [1:0] req;

    logic       a_busrq_n, b_busrq_n;
    logic [1:0] a_gnt, b_gnt, a_yield, b_yield;
    logic       a_busy, b_busy;

    int n_tests = 0;
    int n_fail  = 0;

    z80_bus_arbiter #(.MAX_HOLD(4), .MIN_CPU(4)) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .cen     (cen),
        .busrq_n (a_busrq_n),
        .busak_n (busak_n),
        .req     (req),
        .gnt     (a_gnt),
        .yield   (a_yield),
        .busy    (a_busy)
    );

    z80_bus_arbiter #(.MAX_HOLD(3), .MIN_CPU(0)) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .cen     (cen),
        .busrq_n (b_busrq_n),
        .busak_n (busak_n),
        .req     (req),
        .gnt     (b_gnt),
        .yield   (b_yield),
        .busy    (b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        req     = 2'b00;
        busak_n = 1'b1;
        cen     = 1'b1;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        cen     = 1'b1;
        req     = 2'b00;
        busak_n = 1'b1;
        step();
        step();
        chk("rst_busrq_n", 8'(a_busrq_n), 8'h1);
        chk("rst_gnt",     8'(a_gnt),     8'h0);
        chk("rst_yield",   8'(a_yield),   8'h0);
        chk("rst_busy",    8'(a_busy),    8'h0);
        chk("rst_busy_b",  8'(b_busy),    8'h0);

        // Single requester from reset release, ack three cycles later
        reset_n = 1'b1;
        req     = 2'b01;
        step();
        chk("t030_busrq_e1", 8'(a_busrq_n), 8'h0);
        chk("t030_busy_e1",  8'(a_busy),    8'h1);
        chk("t030_gnt_e1",   8'(a_gnt),     8'h0);
        step();
        step();
        chk("t030_gnt_noack", 8'(a_gnt), 8'h0);
        busak_n = 1'b0;
        step();
        chk("t030_gnt",   8'(a_gnt),     8'h1);
        chk("t030_busrq", 8'(a_busrq_n), 8'h0);
        chk("t030_yield", 8'(a_yield),   8'h0);
        repeat (6) step();
        chk("hold_exp_no_other_yield", 8'(a_yield), 8'h0);
        chk("hold_exp_gnt_kept",       8'(a_gnt),   8'h1);
        req = 2'b00;
        step();
        chk("rel_gnt",   8'(a_gnt),     8'h0);
        chk("rel_busrq", 8'(a_busrq_n), 8'h1);
        chk("rel_busy",  8'(a_busy),    8'h1);
        step();
        chk("rel_waits_ack_busy", 8'(a_busy), 8'h1);
        chk("rel_ack_low_no_gnt", 8'(a_gnt),  8'h0);
        busak_n = 1'b1;
        step();
        chk("rel_to_idle_busy", 8'(a_busy), 8'h0);

        // Tie after owner 0's tenure goes to requester 1, after the gap
        req = 2'b11;
        repeat (4) step();
        chk("gap_holdoff_busrq", 8'(a_busrq_n), 8'h1);
        step();
        chk("gap_done_busrq", 8'(a_busrq_n), 8'h0);
        busak_n = 1'b0;
        step();
        chk("rr_tie_gnt", 8'(a_gnt), 8'h2);
        req = 2'b00;
        step();
        busak_n = 1'b1;
        step();
        chk("rr_tie_idle", 8'(a_busy), 8'h0);

        // Both pending, hold expiry, owner stability, gap then other owner
        do_reset();
        req = 2'b11;
        step();
        chk("t031_busrq", 8'(a_busrq_n), 8'h0);
        busak_n = 1'b0;
        step();
        chk("t031_gnt0", 8'(a_gnt), 8'h1);
        repeat (3) step();
        chk("t031_yield_early", 8'(a_yield), 8'h0);
        step();
        chk("t031_yield", 8'(a_yield), 8'h1);
        req = 2'b01;
        step();
        chk("other_drop_yield", 8'(a_yield), 8'h0);
        chk("other_drop_owner", 8'(a_gnt),   8'h1);
        req = 2'b11;
        step();
        chk("other_back_yield", 8'(a_yield), 8'h1);
        chk("other_back_owner", 8'(a_gnt),   8'h1);
        req = 2'b10;
        step();
        chk("t031_rel_gnt",   8'(a_gnt),     8'h0);
        chk("t031_rel_busrq", 8'(a_busrq_n), 8'h1);
        busak_n = 1'b1;
        step();
        chk("t031_idle", 8'(a_busy), 8'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("t031_gap%0d_busrq", i), 8'(a_busrq_n), 8'h1);
        end
        step();
        chk("t031_gap_end_busrq", 8'(a_busrq_n), 8'h0);
        busak_n = 1'b0;
        step();
        chk("t031_gnt1",   8'(a_gnt),   8'h2);
        chk("t031_yield1", 8'(a_yield), 8'h0);
        req = 2'b00;
        step();
        busak_n = 1'b1;
        step();

        // Request withdrawn before acknowledge
        do_reset();
        req = 2'b01;
        step();
        chk("t032_busrq_low", 8'(a_busrq_n), 8'h0);
        req = 2'b00;
        step();
        chk("t032_gnt",   8'(a_gnt),     8'h0);
        chk("t032_busrq", 8'(a_busrq_n), 8'h1);
        chk("t032_busy",  8'(a_busy),    8'h1);
        step();
        chk("t032_idle_busy", 8'(a_busy), 8'h0);
        chk("t032_idle_gnt",  8'(a_gnt),  8'h0);

        // cen toggling during grant on instance B (MAX_HOLD=3)
        do_reset();
        req = 2'b11;
        step();
        busak_n = 1'b0;
        step();
        chk("t033_gnt", 8'(b_gnt), 8'h1);
        for (int i = 0; i < 3; i++) begin
            cen = 1'b0;
            step();
            chk($sformatf("t033_cen0_%0d_yield", i), 8'(b_yield), 8'h0);
            cen = 1'b1;
            step();
            if (i < 2)
                chk($sformatf("t033_cen1_%0d_yield", i), 8'(b_yield), 8'h0);
            else
                chk("t033_yield", 8'(b_yield), 8'h1);
        end
        chk("t033_a_not_yet", 8'(a_yield), 8'h0);
        cen = 1'b0;
        req = 2'b00;
        step();
        chk("freeze_gnt",   8'(b_gnt),   8'h1);
        chk("freeze_yield", 8'(b_yield), 8'h1);
        cen = 1'b1;
        step();
        chk("unfreeze_rel_gnt", 8'(b_gnt), 8'h0);
        busak_n = 1'b1;
        step();

        // Asynchronous reset in the middle of a grant
        do_reset();
        req = 2'b01;
        step();
        busak_n = 1'b0;
        step();
        chk("t034_gnt_before", 8'(a_gnt), 8'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t034_busrq", 8'(a_busrq_n), 8'h1);
        chk("t034_gnt",   8'(a_gnt),     8'h0);
        chk("t034_busy",  8'(a_busy),    8'h0);
        chk("t034_yield", 8'(a_yield),   8'h0);
        step();
        req     = 2'b00;
        busak_n = 1'b1;
        reset_n = 1'b1;

        // Stray acknowledge while idle never grants
        do_reset();
        busak_n = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk($sformatf("t035_gnt_%0d", i),   8'(a_gnt),     8'h0);
            chk($sformatf("t035_busrq_%0d", i), 8'(a_busrq_n), 8'h1);
        end
        busak_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
